// File: rtl/conv2d_pkg.sv
// Shared types and geometry helpers for the conv2d streaming pipeline stages.
// No logic; used only at elaboration.
package conv2d_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_words(input int width, input int word_width);
        return width / word_width;
    endfunction

    function automatic int calc_tpp(input int channels, input int words);
        return channels / words;
    endfunction

    function automatic int calc_out_xfers(input int tpp, input int pad_h, input int pad_w);
        return tpp * pad_h * pad_w;
    endfunction

    // Counter width that stays at least 1 bit for a single-value range.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster position of the next padded transfer: xfer innermost, then col, then row.
// Latency: counters update on the edge after i_adv; no backpressure of its own.
// Border/last flags are combinational from the current position.
module pad_pos_counter
    import conv2d_pkg::*;
#(
    parameter int TPP   = 2,
    parameter int PAD_W = 6,
    parameter int PAD_H = 6,
    localparam int XW   = cnt_width(TPP),
    localparam int CW   = cnt_width(PAD_W),
    localparam int RW   = cnt_width(PAD_H)
) (
    input  logic          i_aclk,
    input  logic          i_areset,
    input  logic          i_adv,
    input  logic          i_clr,
    output logic [XW-1:0] o_xfer,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_border,
    output logic          o_last
);

    logic [XW-1:0] r_xfer;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_xfer_end;
    logic          w_col_end;
    logic          w_row_end;

    assign w_xfer_end = (r_xfer == XW'(TPP - 1));
    assign w_col_end  = (r_col == CW'(PAD_W - 1));
    assign w_row_end  = (r_row == RW'(PAD_H - 1));

    assign o_xfer   = r_xfer;
    assign o_col    = r_col;
    assign o_row    = r_row;
    assign o_border = (r_row == '0) || w_row_end || (r_col == '0) || w_col_end;
    assign o_last   = w_row_end && w_col_end && w_xfer_end;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_xfer <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_clr) begin
            r_xfer <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_adv) begin
            if (w_xfer_end) begin
                r_xfer <= '0;
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end else begin
                r_xfer <= r_xfer + XW'(1);
            end
        end
    end

endmodule

// File: rtl/conv2d_pad_inserter.sv
// Wraps an HxWxC raster stream in a 1-pixel PAD_VALUE border for "same"-size 3x3 conv.
// Latency: 1 cycle through the output register; one bubble between back-to-back images.
// Backpressure: o_tready follows the output slot and is held low on border positions.
module conv2d_pad_inserter
    import conv2d_pkg::*;
#(
    parameter int IN_HEIGHT  = 4,
    parameter int IN_WIDTH   = 4,
    parameter int IN_CHANNEL = 2,
    parameter int WIDTH      = 8,
    parameter int WORD_WIDTH = 8,
    parameter int PAD_VALUE  = 0
) (
    input  logic             i_aclk,
    input  logic             i_areset,
    input  logic             i_tvalid,
    output logic             o_tready,
    input  logic [WIDTH-1:0] i_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast
);

    localparam int WORDS     = calc_words(WIDTH, WORD_WIDTH);
    localparam int TPP       = calc_tpp(IN_CHANNEL, WORDS);
    localparam int PAD_H     = IN_HEIGHT + 2;
    localparam int PAD_W     = IN_WIDTH + 2;
    localparam int OUT_XFERS = calc_out_xfers(TPP, PAD_H, PAD_W);
    localparam int XW        = cnt_width(TPP);
    localparam int CW        = cnt_width(PAD_W);
    localparam int RW        = cnt_width(PAD_H);

    localparam logic [WORD_WIDTH-1:0] PAD_WORD = WORD_WIDTH'(PAD_VALUE);
    localparam logic [WIDTH-1:0]      PAD_XFER = {WORDS{PAD_WORD}};

    state_t           r_state;
    logic             r_tvalid;
    logic             r_tlast;
    logic [WIDTH-1:0] r_tdata;

    logic          w_slot_free;
    logic          w_border;
    logic          w_last;
    logic          w_load;
    logic          w_run;
    logic [XW-1:0] w_xfer;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;

    pad_pos_counter #(
        .TPP   (TPP),
        .PAD_W (PAD_W),
        .PAD_H (PAD_H)
    ) u_pos (
        .i_aclk   (i_aclk),
        .i_areset (i_areset),
        .i_adv    (w_load),
        .i_clr    (w_load && w_last),
        .o_xfer   (w_xfer),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_border (w_border),
        .o_last   (w_last)
    );

    assign w_run       = (r_state == RUN);
    assign w_slot_free = !r_tvalid || i_tready;
    // Ready never looks at i_tvalid, so upstream sees no combinational loop.
    assign o_tready    = w_run && !w_border && w_slot_free;
    assign w_load      = w_run && w_slot_free && (w_border || i_tvalid);

    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state  <= IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            case (r_state)
                IDLE:    if (i_tvalid) r_state <= RUN;
                RUN:     if (w_load && w_last) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tlast  <= w_last;
                r_tdata  <= w_border ? PAD_XFER : i_tdata;
            end else if (i_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_pad_inserter.sv
// Directed bench: default 4x4/TPP=2 instance plus a 16-bit TPP=1 instance with 8'h80 padding.
module tb_conv2d_pad_inserter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_iv = 1'b0, a_ir = 1'b1;
    logic [7:0]  a_id = '0;
    logic        a_ov, a_ord, a_ol;
    logic [7:0]  a_od;

    logic        b_iv = 1'b0, b_ir = 1'b1;
    logic [15:0] b_id = '0;
    logic        b_ov, b_ord, b_ol;
    logic [15:0] b_od;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] got_a [0:143];

    always #5 clk = ~clk;

    conv2d_pad_inserter u_dut_a (
        .i_aclk   (clk),
        .i_areset (rst),
        .i_tvalid (a_iv),
        .o_tready (a_ord),
        .i_tdata  (a_id),
        .o_tvalid (a_ov),
        .i_tready (a_ir),
        .o_tdata  (a_od),
        .o_tlast  (a_ol)
    );

    conv2d_pad_inserter #(
        .IN_HEIGHT  (4),
        .IN_WIDTH   (4),
        .IN_CHANNEL (2),
        .WIDTH      (16),
        .WORD_WIDTH (8),
        .PAD_VALUE  (8'h80)
    ) u_dut_b (
        .i_aclk   (clk),
        .i_areset (rst),
        .i_tvalid (b_iv),
        .o_tready (b_ord),
        .i_tdata  (b_id),
        .o_tvalid (b_ov),
        .i_tready (b_ir),
        .o_tdata  (b_od),
        .o_tlast  (b_ol)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Input beat idx carries a recognisable value per instance.
    function automatic logic [15:0] in_val(input int sel, input int idx);
        if (sel != 0) return 16'(16'h1100 + idx);
        return {8'h00, 8'(idx + 1)};
    endfunction

    // Expected padded output k from the image geometry (6x6 padded, TPP words per pixel).
    function automatic logic [15:0] exp_out(input int sel, input int k);
        int tpp, outx, nin, img, kk, rl, row, col, x;
        tpp  = (sel != 0) ? 1 : 2;
        outx = 36 * tpp;
        nin  = 16 * tpp;
        img  = k / outx;
        kk   = k % outx;
        rl   = 6 * tpp;
        row  = kk / rl;
        col  = (kk % rl) / tpp;
        x    = kk % tpp;
        if (row == 0 || row == 5 || col == 0 || col == 5)
            return (sel != 0) ? 16'h8080 : 16'h0000;
        return in_val(sel, img * nin + ((row - 1) * 4 + (col - 1)) * tpp + x);
    endfunction

    task automatic run(input int sel, input int nimg, input bit rrand, input bit vrand,
                       input int abort_at);
        int tpp, outx, nin, tot_in, tot_out, in_idx, out_k, cyc, last_cyc;
        logic vld, rdy, acc, stalled, ov, ordy, ol;
        logic [15:0] od, held;
        tpp      = (sel != 0) ? 1 : 2;
        outx     = 36 * tpp;
        nin      = 16 * tpp;
        tot_in   = nimg * nin;
        tot_out  = nimg * outx;
        in_idx   = 0;
        out_k    = 0;
        cyc      = 0;
        last_cyc = -100;
        vld      = 1'b0;
        stalled  = 1'b0;
        held     = '0;
        while (out_k < tot_out && cyc < 3000) begin
            @(negedge clk);
            if (!vld && in_idx < tot_in) vld = vrand ? 1'($urandom_range(1, 0)) : 1'b1;
            rdy = rrand ? 1'($urandom_range(1, 0)) : 1'b1;
            if (sel != 0) begin
                b_iv = vld; b_id = in_val(sel, in_idx); b_ir = rdy;
            end else begin
                a_iv = vld; a_id = 8'(in_val(sel, in_idx)); a_ir = rdy;
            end
            #1;
            ov   = (sel != 0) ? b_ov  : a_ov;
            ordy = (sel != 0) ? b_ord : a_ord;
            ol   = (sel != 0) ? b_ol  : a_ol;
            od   = (sel != 0) ? b_od  : {8'h00, a_od};
            if (stalled) chk("stall_hold", {16'h0, od}, {16'h0, held});
            acc = vld && ordy;
            if (ov && rdy) begin
                chk("data", {16'h0, od}, {16'h0, exp_out(sel, out_k)});
                chk("tlast", {31'h0, ol}, {31'h0, ((out_k % outx) == outx - 1)});
                if (out_k > 0 && (out_k % outx) == 0 && !rrand)
                    chk("img_gap", cyc - last_cyc, 2);
                if (ol) last_cyc = cyc;
                if (sel == 0 && out_k < 144) got_a[out_k] = od;
                out_k++;
            end
            stalled = ov && !rdy;
            held    = od;
            if (abort_at >= 0 && out_k == abort_at) break;
            @(posedge clk);
            if (acc) begin
                vld = 1'b0;
                in_idx++;
            end
            cyc++;
        end
        a_iv = 1'b0; b_iv = 1'b0; a_ir = 1'b1; b_ir = 1'b1;
        if (abort_at < 0) begin
            chk("out_count", out_k, tot_out);
            chk("in_count", in_idx, tot_in);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_tvalid", {31'h0, a_ov}, 0);
        chk("rst_tlast", {31'h0, a_ol}, 0);
        chk("rst_tdata", {24'h0, a_od}, 0);
        chk("rst_tready", {31'h0, a_ord}, 0);
        chk("rst_b_tvalid", {31'h0, b_ov}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // No input for 20 cycles: nothing emitted
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("idle_tvalid", {31'h0, a_ov}, 0);
        end
        chk("idle_tready", {31'h0, a_ord}, 0);

        // Sink always ready, input always valid
        run(0, 1, 1'b0, 1'b0, -1);
        chk("out13", {16'h0, got_a[13]}, 0);
        chk("out14", {16'h0, got_a[14]}, 1);
        chk("out15", {16'h0, got_a[15]}, 2);
        chk("out16", {16'h0, got_a[16]}, 3);
        chk("out22", {16'h0, got_a[22]}, 0);
        chk("out27", {16'h0, got_a[27]}, 10);
        chk("out57", {16'h0, got_a[57]}, 32);
        chk("out58", {16'h0, got_a[58]}, 0);

        // Random backpressure and random valid
        run(0, 1, 1'b1, 1'b1, -1);

        // Two images back to back
        run(0, 2, 1'b0, 1'b0, -1);

        // Reset mid-image, then a fresh image
        run(0, 1, 1'b0, 1'b0, 31);
        chk("pre_rst_tvalid", {31'h0, a_ov}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tvalid", {31'h0, a_ov}, 0);
        chk("async_rst_tdata", {24'h0, a_od}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(0, 1, 1'b0, 1'b0, -1);

        // Wide instance: TPP=1, 8'h80 border words
        run(1, 1, 1'b0, 1'b0, -1);
        run(1, 1, 1'b1, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
